uart_mmio: RTL and testbench

Memory-mapped 8N1 UART for the MIPS CPU peripheral bus. It combines a serial receiver and transmitter with the UART register window of the data-memory peripheral map. The CPU sends a byte by writing UART_TXD and collects a received byte by reading UART_RXD. Status and interrupt enables live in UART_CON, and the block raises an interrupt request on RX/TX events.

---
 rtl/uart_mmio_if.sv | 12 +
 rtl/uart_mmio.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_if.sv
// CPU peripheral bus bundle for the UART register window.
// The CPU side drives strobes, address and write data; the peripheral returns read data.
interface uart_mmio_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output read, output write, output addr, output wdata, input rdata);
  modport slave  (input read, input write, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: a serial receiver and transmitter behind the TXD/RXD/CON registers.
// It raises a level interrupt on RX data available and on TX frame done.
module uart_mmio #(
  parameter int unsigned BAUD_DIV = 10416,
  parameter logic [31:0] ADDR_TXD = 32'h4000_0018,
  parameter logic [31:0] ADDR_RXD = 32'h4000_001C,
  parameter logic [31:0] ADDR_CON = 32'h4000_0020
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        RX_EFF,
  output logic        TX_STATUS,
  output logic        interrupt,
  uart_mmio_if.slave  bus
);

  localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e           rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [2:0]       rx_sync_q, rx_sync_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [7:0]       rxd_q, rxd_d, txd_q, txd_d;
  logic             rx_eff_q, rx_eff_d, ovr_q, ovr_d, fe_q, fe_d;
  logic             tx_q, tx_d, tx_status_q, tx_status_d, tx_done_q, tx_done_d;
  logic             tx_ie_q, tx_ie_d, rx_ie_q, rx_ie_d, irq_q, irq_d;

  logic rx_line, rx_fall, rx_load, rx_ferr, tx_done_set;
  logic rd_rxd, rd_con, wr_txd, wr_con, tx_accept;
  logic unused_wdata;

  assign rd_rxd    = bus.read  && (bus.addr == ADDR_RXD);
  assign rd_con    = bus.read  && (bus.addr == ADDR_CON);
  assign wr_txd    = bus.write && (bus.addr == ADDR_TXD);
  assign wr_con    = bus.write && (bus.addr == ADDR_CON);
  assign tx_accept = wr_txd && tx_status_q;

  // rx_sync_q: [0] first stage, [1] synchronised line, [2] previous value for edge detect
  assign rx_line      = rx_sync_q[1];
  assign rx_fall      = rx_sync_q[2] & ~rx_sync_q[1];
  assign unused_wdata = ^bus.wdata[31:8];

  // Next-state logic for both serial engines and the register file
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_sync_d   = {rx_sync_q[1:0], UART_RX};
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    txd_d       = txd_q;
    tx_d        = 1'b1;
    rx_load     = 1'b0;
    rx_ferr     = 1'b0;
    tx_ie_d     = tx_ie_q;
    rx_ie_d     = rx_ie_q;

    unique case (rx_state_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_line ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          rx_load    = rx_line;
          rx_ferr    = ~rx_line;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase

    // UART_TX follows the registered state one cycle later, so the line goes low after the write edge
    unique case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_accept) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_shift_d = bus.wdata[7:0];
          txd_d      = bus.wdata[7:0];
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        tx_d = tx_shift_q[0];
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    // Ready rises together with the end of the stop bit on the line
    tx_status_d = (tx_state_q == S_IDLE) && !tx_accept;
    tx_done_set = (tx_state_q == S_IDLE) && !tx_status_q;

    if (wr_con) begin
      tx_ie_d = bus.wdata[0];
      rx_ie_d = bus.wdata[1];
    end

    // New events win over read-to-clear in the same cycle
    rxd_d     = rx_load ? rx_shift_q : rxd_q;
    rx_eff_d  = rx_load ? 1'b1 : (rd_rxd ? 1'b0 : rx_eff_q);
    ovr_d     = (rx_load && rx_eff_q) ? 1'b1 : (rd_con ? 1'b0 : ovr_q);
    fe_d      = rx_ferr     ? 1'b1 : (rd_con ? 1'b0 : fe_q);
    tx_done_d = tx_done_set ? 1'b1 : (rd_con ? 1'b0 : tx_done_q);
    irq_d     = (rx_ie_d & rx_eff_d) | (tx_ie_d & tx_done_d);
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      rx_state_q  <= S_IDLE;
      tx_state_q  <= S_IDLE;
      rx_sync_q   <= 3'b111;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      tx_bit_q    <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rxd_q       <= '0;
      txd_q       <= '0;
      rx_eff_q    <= 1'b0;
      ovr_q       <= 1'b0;
      fe_q        <= 1'b0;
      tx_q        <= 1'b1;
      tx_status_q <= 1'b1;
      tx_done_q   <= 1'b0;
      tx_ie_q     <= 1'b0;
      rx_ie_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      rx_sync_q   <= rx_sync_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      tx_bit_q    <= tx_bit_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rxd_q       <= rxd_d;
      txd_q       <= txd_d;
      rx_eff_q    <= rx_eff_d;
      ovr_q       <= ovr_d;
      fe_q        <= fe_d;
      tx_q        <= tx_d;
      tx_status_q <= tx_status_d;
      tx_done_q   <= tx_done_d;
      tx_ie_q     <= tx_ie_d;
      rx_ie_q     <= rx_ie_d;
      irq_q       <= irq_d;
    end
  end

  // Combinational read mux; unmapped addresses read as zero
  always_comb begin
    bus.rdata = '0;
    if (bus.read) begin
      if (bus.addr == ADDR_TXD)      bus.rdata = {24'd0, txd_q};
      else if (bus.addr == ADDR_RXD) bus.rdata = {24'd0, rxd_q};
      else if (bus.addr == ADDR_CON)
        bus.rdata = {25'd0, fe_q, ovr_q, tx_status_q, rx_eff_q, tx_done_q, rx_ie_q, tx_ie_q};
    end
  end

  assign UART_TX   = tx_q;
  assign RX_EFF    = rx_eff_q;
  assign TX_STATUS = tx_status_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed plus randomized bench for uart_mmio against a frame-level model of the UART registers.
module tb_uart_mmio;

  localparam int BD = 16;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic clk, rst, rx, tx, rx_eff, tx_status, irq;
  uart_mmio_if bus();

  uart_mmio #(.BAUD_DIV(BD)) dut (
    .sysclk    (clk),
    .reset     (rst),
    .UART_RX   (rx),
    .UART_TX   (tx),
    .RX_EFF    (rx_eff),
    .TX_STATUS (tx_status),
    .interrupt (irq),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Register-level model
  logic [7:0] m_rxd, m_txd;
  logic m_eff, m_ovr, m_fe, m_txdone, m_txie, m_rxie, m_txbusy;

  function automatic logic [31:0] exp_con();
    return {25'd0, m_fe, m_ovr, ~m_txbusy, m_eff, m_txdone, m_rxie, m_txie};
  endfunction

  function automatic logic exp_irq();
    return (m_rxie & m_eff) | (m_txie & m_txdone);
  endfunction

  task automatic model_reset();
    m_rxd = '0; m_txd = '0; m_eff = 0; m_ovr = 0; m_fe = 0;
    m_txdone = 0; m_txie = 0; m_rxie = 0; m_txbusy = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // One-cycle read starting at a falling edge; rdata sampled mid low phase
  task automatic read_chk(input string tag, input logic [31:0] a);
    logic [31:0] want, got;
    if (a == A_TXD)      want = {24'd0, m_txd};
    else if (a == A_RXD) want = {24'd0, m_rxd};
    else if (a == A_CON) want = exp_con();
    else                 want = '0;
    bus.read = 1'b1; bus.addr = a;
    #1 got = bus.rdata;
    chk(tag, got, want);
    @(negedge clk);
    bus.read = 1'b0; bus.addr = '0;
    if (a == A_RXD) m_eff = 0;
    if (a == A_CON) begin m_txdone = 0; m_ovr = 0; m_fe = 0; end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.write = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
    if (a == A_TXD && !m_txbusy) begin m_txd = d[7:0]; m_txbusy = 1; end
    if (a == A_CON) begin m_txie = d[0]; m_rxie = d[1]; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      if (k == 9) chk("rx_eff_before_stop", 32'(rx_eff), 32'(m_eff));
      rx = f[k];
      repeat (BD) @(negedge clk);
    end
    if (stop) begin
      if (m_eff) m_ovr = 1;
      m_rxd = b; m_eff = 1;
    end else begin
      m_fe = 1;
    end
    chk("rx_eff_after_frame", 32'(rx_eff), 32'(m_eff));
    chk("irq_after_frame", 32'(irq), 32'(exp_irq()));
    if (!stop) begin
      rx = 1'b1;
      repeat (BD) @(negedge clk);
    end
  endtask

  // Call right after bus_write returns; n counts falling edges since the accepting edge
  task automatic tx_frame(input logic [7:0] b, input logic poke);
    logic [9:0] f;
    logic want_tx;
    int k;
    f = {1'b1, b, 1'b0};
    for (int n = 0; n <= 10 * BD + 1; n++) begin
      if (n > 0) @(negedge clk);
      k = (n - 1) / BD;
      want_tx = (n == 0 || k >= 10) ? 1'b1 : f[k];
      chk("uart_tx_bit", 32'(tx), 32'(want_tx));
      chk("tx_status_frame", 32'(tx_status), 32'(n >= 10 * BD + 1));
      if (poke && n == 40) begin bus.write = 1'b1; bus.addr = A_TXD; bus.wdata = 32'hCC; end
      if (poke && n == 41) begin bus.write = 1'b0; bus.addr = '0; bus.wdata = '0; end
    end
    m_txbusy = 0; m_txdone = 1;
    chk("irq_tx_done", 32'(irq), 32'(exp_irq()));
  endtask

  initial begin
    logic [7:0] b;
    logic stop;
    model_reset();
    rst = 1'b0; rx = 1'b1;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("reset_uart_tx", 32'(tx), 32'd1);
    chk("reset_tx_status", 32'(tx_status), 32'd1);
    chk("reset_rx_eff", 32'(rx_eff), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    read_chk("con_after_reset", A_CON);

    // Receive 0x01
    send_frame(8'h01, 1'b1);
    read_chk("rxd_01", A_RXD);
    chk("rx_eff_cleared", 32'(rx_eff), 32'd0);

    // Transmit 0x55 with a dropped write of 0xCC mid-frame
    bus_write(A_TXD, 32'h55);
    tx_frame(8'h55, 1'b1);
    read_chk("txd_after_busy_write", A_TXD);
    read_chk("con_tx_done", A_CON);

    // Unmapped accesses
    bus_write(32'h4000_0024, 32'hFFFF_FFFF);
    read_chk("unmapped_read", 32'h4000_0024);

    // Interrupts
    bus_write(A_CON, 32'h3);
    send_frame(8'hA5, 1'b1);
    read_chk("rxd_a5", A_RXD);
    chk("irq_after_rxd_read", 32'(irq), 32'(exp_irq()));
    bus_write(A_TXD, 32'h3C);
    tx_frame(8'h3C, 1'b0);
    send_frame(8'h5A, 1'b1);
    read_chk("rxd_5a", A_RXD);
    chk("irq_held_by_tx_done", 32'(irq), 32'(exp_irq()));
    read_chk("con_irq", A_CON);
    chk("irq_cleared", 32'(irq), 32'(exp_irq()));
    bus_write(A_CON, 32'h0);

    // Overrun, then framing error
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    read_chk("rxd_overrun", A_RXD);
    read_chk("con_overrun", A_CON);
    send_frame(8'h66, 1'b1);
    send_frame(8'h77, 1'b0);
    chk("rx_eff_kept_on_ferr", 32'(rx_eff), 32'(m_eff));
    read_chk("con_ferr", A_CON);
    read_chk("con_sticky_cleared", A_CON);
    read_chk("rxd_after_ferr", A_RXD);

    // False start
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BD) @(negedge clk);
    chk("false_start_rx_eff", 32'(rx_eff), 32'd0);
    read_chk("false_start_con", A_CON);
    send_frame(8'hC3, 1'b1);
    read_chk("rxd_after_false_start", A_RXD);

    // Randomized receive traffic
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop);
      if ($urandom_range(0, 1) == 1) read_chk("rand_rxd", A_RXD);
      if ($urandom_range(0, 1) == 1) read_chk("rand_con", A_CON);
    end
    read_chk("rand_rxd_final", A_RXD);

    // Randomized transmit traffic, each write issued in the first ready cycle
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      bus_write(A_TXD, {24'd0, b});
      tx_frame(b, 1'b0);
    end
    read_chk("rand_txd", A_TXD);
    read_chk("rand_tx_con", A_CON);

    // Reset in the middle of both frames
    bus_write(A_TXD, 32'hF0);
    rx = 1'b0;
    repeat (3 * BD) @(negedge clk);
    rst = 1'b0; rx = 1'b1;
    @(negedge clk);
    model_reset();
    chk("midreset_uart_tx", 32'(tx), 32'd1);
    chk("midreset_tx_status", 32'(tx_status), 32'd1);
    chk("midreset_irq", 32'(irq), 32'd0);
    rst = 1'b1;
    repeat (12 * BD) @(negedge clk);
    chk("midreset_rx_eff", 32'(rx_eff), 32'd0);
    chk("midreset_line_idle", 32'(tx), 32'd1);
    read_chk("midreset_rxd", A_RXD);
    read_chk("midreset_txd", A_TXD);
    read_chk("midreset_con", A_CON);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
